mem_burst_seq: RTL and testbench
================================

// Module: mem_burst_seq
// PURPOSE
//  Burst load/store sequencer that sits directly upstream of the 32x8 register memory.
//  Accepts one command (read or write, start address, length), then streams data.
//  Write beats come in on a valid/ready port; read data goes out on a valid/ready port.
//  Drives the memory's addr/data_in/wen and consumes its data_out, which is registered
//  with one-cycle read latency.
// PARAMETERS
//  DATA_WIDTH  8  width of a memory word and of wr_data/rd_data
//  ADDR_BITS   5  memory address width; also the width of cmd_len (beats-1)
//  RD_DEPTH    4  entries in the read-return FIFO; fixed power of two, >=4
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous, active-low reset
//  cmd_valid    in   1           command offered
//  cmd_ready    out  1           high only in IDLE
//  cmd_write    in   1           1=write burst, 0=read burst
//  cmd_addr     in   ADDR_BITS   start address
//  cmd_len      in   ADDR_BITS   beats minus one (0 -> 1 beat, 31 -> 32 beats)
//  wr_valid     in   1           write beat offered
//  wr_ready     out  1           high only in WRITE state
//  wr_data      in   DATA_WIDTH  write beat data
//  rd_valid     out  1           read-return FIFO not empty
//  rd_ready     in   1           consumer accepts rd_data
//  rd_data      out  DATA_WIDTH  head of read-return FIFO
//  done         out  1           one-cycle pulse when a burst completes
//  mem_addr     out  ADDR_BITS   to memory addr (registered)
//  mem_data_in  out  DATA_WIDTH  to memory data_in (registered)
//  mem_wen      out  1           to memory wen (registered)
//  mem_data_out in   DATA_WIDTH  from memory data_out
// BEHAVIOUR
//  Reset (async, rst_n low):
//   - state=IDLE; FIFO and in-flight tracking cleared.
//   - mem_wen, mem_addr, mem_data_in, done, rd_valid all 0. No output is X after reset.
//  States: IDLE, WRITE, READ.
//   - IDLE: on cmd_valid&&cmd_ready, latch cur_addr=cmd_addr and beats=cmd_len.
//     Go to WRITE or READ per cmd_write.
//   - Commands are taken only in IDLE; cmd_valid in other states is ignored and stays pending.
//  WRITE:
//   - Each edge with wr_valid&&wr_ready registers mem_wen=1, mem_addr=cur_addr, mem_data_in=wr_data.
//     The memory commits the beat on the following edge.
//   - Without a beat, mem_wen is registered 0.
//   - After the last beat, go to IDLE; done=1 for exactly the next cycle.
//  READ:
//   - Issue = register mem_wen=0, mem_addr=cur_addr.
//   - The memory returns the word after the next edge; it is captured into the FIFO one edge
//     after that (2 edges from issue).
//   - Issue is allowed only if fifo_count + in_flight - pop < RD_DEPTH, where
//     pop = rd_valid&&rd_ready in the same cycle. The FIFO never overflows.
//   - First issue happens on the edge after command accept.
//   - With rd_ready held high: first rd_valid 3 cycles after accept, then 1 beat/cycle.
//   - After all beats are issued, stop issuing. Go to IDLE on the edge of the final rd handshake,
//     once nothing is in flight and the FIFO is empty. done=1 for the next cycle.
//  Ordering: rd_data order equals issue order. No drop, no duplicate.
//  Addresses: cur_addr increments by 1 per issued or written beat, modulo 2**ADDR_BITS (31->0).
//  mem_data_out is ignored except in capture cycles. The memory's 0 output after writes is never returned.
//  A new command is accepted in the same cycle done is high (cmd_ready=1 then).
//  Reset mid-burst: burst abandoned, in-flight reads discarded, mem_wen low at once.
//  Memory contents are not touched.
// TESTING
//  1) Write cmd addr=3 len=3, wr_data 0x11,0x22,0x33,0x44 back-to-back
//     -> mem[3..6]=11,22,33,44; single done pulse.
//  2) Read cmd addr=3 len=3, rd_ready=1
//     -> rd_data 11,22,33,44 on consecutive cycles, first 3 cycles after accept; done once.
//  3) Write addr=30 len=3 with wr_valid gaps every other cycle
//     -> mem[30],[31],[0],[1] written; mem_wen low in gap cycles.
//  4) Read 32 beats with rd_ready toggling 1,0,0,1...
//     -> all 32 words in order; FIFO never exceeds RD_DEPTH; no beat lost.
//  5) cmd_valid held during an active burst
//     -> not accepted until the done cycle; accepted on that edge.
//  6) rst_n low mid-read (beat 2 of 8)
//     -> rd_valid/mem_wen/done 0 immediately; IDLE; next command runs normally.

Source files
------------

// File: rtl/mem_burst_seq.sv
// mem_burst_seq: burst load/store sequencer in front of a 32x8 register memory.
// Reads go through a two-edge memory pipeline and return via a small FIFO.
module mem_burst_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int RD_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_BITS-1:0]  cmd_addr,
    input  logic [ADDR_BITS-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam int PW = $clog2(RD_DEPTH);
    localparam int CW = PW + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;

    logic [1:0]            state;
    logic [ADDR_BITS-1:0]  cur_addr;
    logic [ADDR_BITS-1:0]  beats;
    logic                  issue_done;
    logic                  v1;
    logic                  v2;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] fifo_q [RD_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic                  wr_fire;
    logic                  pop;
    logic                  push;
    logic                  last_beat;
    logic                  can_issue;
    logic                  rd_last;
    logic [CW-1:0]         occ;

    assign cmd_ready = (state == S_IDLE);
    assign wr_ready  = (state == S_WRITE);
    assign rd_valid  = (count != '0);
    assign rd_data   = fifo_q[rd_ptr];
    assign done      = done_q;

    assign wr_fire   = wr_valid && wr_ready;
    assign pop       = rd_valid && rd_ready;
    assign push      = v2;
    assign last_beat = (beats == '0);

    // Occupancy counts reads still in the memory pipeline so the FIFO can't overflow.
    assign occ = count + CW'(v1) + CW'(v2) - CW'(pop);

    assign can_issue = (state == S_READ) && !issue_done
                    && (occ < CW'(RD_DEPTH));

    assign rd_last = (state == S_READ) && issue_done && !v1 && !v2
                  && (count == CW'(1)) && pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cur_addr   <= '0;
            beats      <= '0;
            issue_done <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr   <= cmd_addr;
                        beats      <= cmd_len;
                        issue_done <= 1'b0;
                        state      <= cmd_write ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (wr_fire) begin
                        cur_addr <= cur_addr + ADDR_BITS'(1);
                        if (last_beat) begin
                            state <= S_IDLE;
                        end else begin
                            beats <= beats - ADDR_BITS'(1);
                        end
                    end
                end
                S_READ: begin
                    if (can_issue) begin
                        cur_addr <= cur_addr + ADDR_BITS'(1);
                        if (last_beat) begin
                            issue_done <= 1'b1;
                        end else begin
                            beats <= beats - ADDR_BITS'(1);
                        end
                    end
                    if (rd_last) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wen     <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            done_q      <= 1'b0;
            v1          <= 1'b0;
            v2          <= 1'b0;
        end else begin
            mem_wen <= wr_fire;
            if (wr_fire || can_issue) begin
                mem_addr <= cur_addr;
            end
            if (wr_fire) begin
                mem_data_in <= wr_data;
            end
            done_q <= (wr_fire && last_beat) || rd_last;
            // v1: address on the bus; v2: word valid on mem_data_out.
            v1 <= can_issue;
            v2 <= v1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= mem_data_out;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_mem_burst_seq.sv
// tb_mem_burst_seq: directed bench for mem_burst_seq with a 32x8 memory model.
// Burst table plus hand-written sequences for held commands and mid-burst reset.
module tb_mem_burst_seq;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [4:0] cmd_addr;
    logic [4:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       done;
    logic [4:0] mem_addr;
    logic [7:0] mem_data_in;
    logic       mem_wen;
    logic [7:0] mem_data_out;

    logic [7:0] tmem    [32];
    logic [7:0] ref_mem [32];

    int n_chk;
    int n_fail;

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [4:0] len;
        int         mode;
        logic [7:0] base;
        int         lat;
        logic [4:0] last;
    } vec_t;

    vec_t tbl [9];

    mem_burst_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_wen      (mem_wen),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register memory: one-cycle read latency, outputs 0 in write cycles.
    always @(posedge clk) begin
        if (mem_wen) begin
            tmem[mem_addr] <= mem_data_in;
            mem_data_out   <= 8'h00;
        end else begin
            mem_data_out <= tmem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_mem(input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (tmem[i] !== ref_mem[i]) bad++;
        end
        chk({nm, "_mem"}, bad, 0);
    endtask

    task automatic do_write(input vec_t v, input string nm);
        int         beat;
        int         cyc;
        int         dones;
        logic [4:0] ea;
        logic [7:0] d;
        logic       fire;
        beat  = 0;
        cyc   = 0;
        dones = 0;
        ea    = v.addr;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({nm, "_wr_ready"}, wr_ready, 1);
        chk({nm, "_cmd_busy"}, cmd_ready, 0);
        while (beat <= int'(v.len) && cyc < 200) begin
            fire = (v.mode == 0) || (cyc % 2 == 0);
            d = v.base + 8'(beat * 17);
            wr_valid = fire;
            wr_data  = d;
            @(negedge clk);
            if (fire) begin
                chk({nm, "_wen"}, mem_wen, 1);
                chk({nm, "_addr"}, mem_addr, ea);
                chk({nm, "_wdata"}, mem_data_in, d);
                ref_mem[ea] = d;
                ea = ea + 5'd1;
                beat++;
            end else begin
                chk({nm, "_gap_wen"}, mem_wen, 0);
            end
            chk({nm, "_done"}, done, fire && (beat == int'(v.len) + 1));
            if (done) dones++;
            cyc++;
        end
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        chk({nm, "_beats"}, beat, int'(v.len) + 1);
        @(negedge clk);
        if (done) dones++;
        chk({nm, "_dones"}, dones, 1);
        chk({nm, "_idle"}, cmd_ready, 1);
        chk({nm, "_wen_off"}, mem_wen, 0);
        chk({nm, "_last_addr"}, mem_addr, v.last);
        chk_mem(nm);
    endtask

    task automatic rd_collect(input logic [4:0] a, input logic [4:0] l,
                              input int mode, input int exp_lat,
                              input string nm);
        int         cyc;
        int         got;
        int         first;
        int         last_cyc;
        int         done_cyc;
        int         dones;
        int         wen_seen;
        logic [4:0] ea;
        cyc      = 0;
        got      = 0;
        first    = -1;
        last_cyc = -10;
        done_cyc = -1;
        dones    = 0;
        wen_seen = 0;
        ea       = a;
        while (cyc < 400) begin
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (mem_wen) wen_seen++;
            if (rd_valid && first < 0) first = cyc;
            rd_ready = (mode == 0) || (cyc % 3 == 0);
            if (rd_valid && rd_ready) begin
                chk({nm, "_rdata"}, rd_data, ref_mem[ea]);
                ea = ea + 5'd1;
                got++;
                if (got == int'(l) + 1) last_cyc = cyc;
            end
            if (got == int'(l) + 1 && cyc >= last_cyc + 2) break;
            @(negedge clk);
            cyc++;
        end
        rd_ready = 1'b0;
        chk({nm, "_beats"}, got, int'(l) + 1);
        chk({nm, "_dones"}, dones, 1);
        chk({nm, "_done_cyc"}, done_cyc, last_cyc + 1);
        chk({nm, "_latency"}, first, exp_lat);
        if (mode == 0) chk({nm, "_last_cyc"}, last_cyc, exp_lat + int'(l));
        chk({nm, "_no_wen"}, wen_seen, 0);
        chk({nm, "_rd_empty"}, rd_valid, 0);
        chk({nm, "_idle"}, cmd_ready, 1);
    endtask

    task automatic do_read(input vec_t v, input string nm);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({nm, "_cmd_busy"}, cmd_ready, 0);
        rd_collect(v.addr, v.len, v.mode, v.lat, nm);
        chk({nm, "_last_addr"}, mem_addr, v.last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t hv;
        n_chk  = 0;
        n_fail = 0;
        // wr, addr, len, mode, base, first-rd latency, last mem_addr
        tbl[0] = '{1'b1, 5'd3,  5'd3,  0, 8'h11, 0, 5'd6};
        tbl[1] = '{1'b0, 5'd3,  5'd3,  0, 8'h00, 3, 5'd6};
        tbl[2] = '{1'b1, 5'd30, 5'd3,  1, 8'hA1, 0, 5'd1};
        tbl[3] = '{1'b0, 5'd30, 5'd3,  0, 8'h00, 3, 5'd1};
        tbl[4] = '{1'b1, 5'd0,  5'd31, 0, 8'h07, 0, 5'd31};
        tbl[5] = '{1'b0, 5'd0,  5'd31, 2, 8'h00, 3, 5'd31};
        tbl[6] = '{1'b0, 5'd5,  5'd0,  0, 8'h00, 3, 5'd5};
        tbl[7] = '{1'b1, 5'd31, 5'd0,  0, 8'h99, 0, 5'd31};
        tbl[8] = '{1'b0, 5'd31, 5'd0,  0, 8'h00, 3, 5'd31};

        for (int i = 0; i < 32; i++) begin
            tmem[i]    = 8'hE0 ^ 8'(i);
            ref_mem[i] = 8'hE0 ^ 8'(i);
        end
        mem_data_out = 8'h00;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 5'd0;
        cmd_len   = 5'd0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        rd_ready  = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wen", mem_wen, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_data_in, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wr_ready", wr_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].wr) do_write(tbl[i], $sformatf("v%0d", i));
            else           do_read(tbl[i], $sformatf("v%0d", i));
        end

        // Command held through a write burst, taken on the done edge.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 5'd10;
        cmd_len   = 5'd1;
        @(negedge clk);
        cmd_write = 1'b0;
        chk("t5_busy", cmd_ready, 0);
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        @(negedge clk);
        ref_mem[10] = 8'h5A;
        chk("t5_wen0", mem_wen, 1);
        chk("t5_done0", done, 0);
        chk("t5_busy2", cmd_ready, 0);
        wr_data = 8'h5B;
        @(negedge clk);
        ref_mem[11] = 8'h5B;
        wr_valid = 1'b0;
        chk("t5_done1", done, 1);
        chk("t5_ready_on_done", cmd_ready, 1);
        @(negedge clk);
        chk("t5_accepted", cmd_ready, 0);
        chk("t5_not_write", wr_ready, 0);
        cmd_valid = 1'b0;
        rd_collect(5'd10, 5'd1, 0, 3, "t5");

        // Reset while beat 2 of an 8-beat read is waiting.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 5'd0;
        cmd_len   = 5'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        rd_ready  = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_pre_valid", rd_valid, 1);
        chk("t6_pre_data", rd_data, ref_mem[2]);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_wen", mem_wen, 0);
        chk("t6_done", done, 0);
        chk("t6_idle", cmd_ready, 1);
        @(negedge clk);
        rst_n    = 1'b1;
        rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_flushed", rd_valid, 0);
        chk("t6_still_idle", cmd_ready, 1);
        chk_mem("t6");
        hv = '{1'b0, 5'd3, 5'd3, 0, 8'h00, 3, 5'd6};
        do_read(hv, "t6_after");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
